// File: rtl/alu_unit.sv
// RV32I R-type fetch/decode/execute core with a combinational ALU.
// Optional build macro PC_HALT_EN: stop fetching on the first non-R-type word.
module alu_unit #(
    parameter int XLEN       = 32,
    parameter int IMEM_DEPTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic [31:0]     instr,
    output logic [6:0]      opcode,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic [4:0]      rd_addr,
    output logic [2:0]      func,
    output logic [3:0]      ctrl_sig,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] rd_data,
    output logic            wr_en
);

    localparam int AW = $clog2(IMEM_DEPTH);
    localparam logic [6:0] OP_R = 7'b0110011;

    logic [AW-1:0] PC;
    logic [31:0]   Instr_mem [0:IMEM_DEPTH-1];

    logic            w_is_r;
    logic            w_halt;
    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_alu;

    assign opcode   = instr[6:0];
    assign rd_addr  = instr[11:7];
    assign func     = instr[14:12];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];
    assign w_is_r   = (opcode == OP_R);
    assign w_shamt  = rs2_data[4:0];

    // Only ADD/SUB and SRL/SRA are distinguished by instr[30].
    assign ctrl_sig = (func == 3'b000 || func == 3'b101) ?
                      {instr[30], func} : {1'b0, func};

`ifdef PC_HALT_EN
    // r_run keeps the reset value of instr (opcode 0) from halting the core.
    logic r_run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    assign w_halt = r_run & ~w_is_r;
`else
    assign w_halt = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC    <= '0;
            instr <= '0;
        end else if (!w_halt) begin
            instr <= Instr_mem[PC];
            PC    <= PC + AW'(1);
        end
    end

    always_comb begin
        w_alu = '0;
        unique case (ctrl_sig)
            4'b0000: w_alu = rs1_data + rs2_data;
            4'b1000: w_alu = rs1_data - rs2_data;
            4'b0001: w_alu = rs1_data << w_shamt;
            4'b0010: w_alu = XLEN'($signed(rs1_data) < $signed(rs2_data));
            4'b0011: w_alu = XLEN'(rs1_data < rs2_data);
            4'b0100: w_alu = rs1_data ^ rs2_data;
            4'b0101: w_alu = rs1_data >> w_shamt;
            4'b1101: w_alu = $signed(rs1_data) >>> w_shamt;
            4'b0110: w_alu = rs1_data | rs2_data;
            4'b0111: w_alu = rs1_data & rs2_data;
            default: w_alu = '0;
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        rd_data = '0;
        if (w_is_r) begin
            wr_en   = 1'b1;
            rd_data = w_alu;
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Directed bench for alu_unit with a behavioural register bank.
module tb_alu_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [2:0]  func;
    logic [3:0]  ctrl_sig;
    logic [31:0] rs1_data, rs2_data, rd_data;
    logic        wr_en;

    logic [31:0] regs      [0:31];
    logic [31:0] init_regs [0:31];
    logic        bank_load;
    int          wr_cnt;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    alu_unit #(.XLEN(32), .IMEM_DEPTH(32)) dut (
        .clk(clk), .rst(rst), .instr(instr), .opcode(opcode),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .func(func), .ctrl_sig(ctrl_sig), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .rd_data(rd_data), .wr_en(wr_en)
    );

    assign rs1_data = regs[rs1_addr];
    assign rs2_data = regs[rs2_addr];

    always @(posedge clk) begin
        if (bank_load) begin
            for (int i = 0; i < 32; i++) regs[i] <= init_regs[i];
            wr_cnt <= 0;
        end else if (wr_en) begin
            regs[rd_addr] <= rd_data;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] rtype(input logic [6:0] f7,
        input logic [4:0] s2, input logic [4:0] s1,
        input logic [2:0] f3, input logic [4:0] rd);
        return {f7, s2, s1, f3, rd, 7'b0110011};
    endfunction

    task automatic set_init(input logic [31:0] r5, input logic [31:0] r9);
        for (int i = 0; i < 32; i++) init_regs[i] = 32'h0;
        init_regs[0] = 32'h0000000F;
        init_regs[1] = 32'h0000000C;
        init_regs[4] = 32'hFF0000FF;
        init_regs[5] = r5;
        init_regs[7] = 32'h70000000;
        init_regs[8] = 32'hF0000000;
        init_regs[9] = r9;
    endtask

    // Hold reset for one edge while the bank is reloaded, then release.
    task automatic restart();
        rst = 1'b1;
        bank_load = 1'b1;
        tick(1);
        bank_load = 1'b0;
        rst = 1'b0;
    endtask

    logic [3:0] exp_ctrl [0:9];
    int         snap;
    int         budget;

    initial begin
        exp_ctrl = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                     4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};
        for (int i = 0; i < 32; i++) dut.Instr_mem[i] = 32'h0;
        dut.Instr_mem[0]  = rtype(7'h00, 5'd1, 5'd0, 3'b000, 5'd2);
        dut.Instr_mem[1]  = rtype(7'h20, 5'd1, 5'd0, 3'b000, 5'd3);
        dut.Instr_mem[2]  = rtype(7'h00, 5'd5, 5'd4, 3'b001, 5'd6);
        dut.Instr_mem[3]  = rtype(7'h00, 5'd8, 5'd7, 3'b010, 5'd9);
        dut.Instr_mem[4]  = rtype(7'h00, 5'd8, 5'd7, 3'b011, 5'd10);
        dut.Instr_mem[5]  = rtype(7'h00, 5'd1, 5'd0, 3'b100, 5'd11);
        dut.Instr_mem[6]  = rtype(7'h00, 5'd5, 5'd4, 3'b101, 5'd12);
        dut.Instr_mem[7]  = rtype(7'h20, 5'd5, 5'd4, 3'b101, 5'd13);
        dut.Instr_mem[8]  = rtype(7'h20, 5'd1, 5'd0, 3'b110, 5'd14);
        dut.Instr_mem[9]  = rtype(7'h00, 5'd1, 5'd0, 3'b111, 5'd15);
        dut.Instr_mem[10] = 32'h00000013;

        set_init(32'd4, 32'h0);
        rst = 1'b1;
        bank_load = 1'b1;
        tick(1);
        bank_load = 1'b0;
        check("rst_pc", 32'(dut.PC), 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_wr_en", 32'(wr_en), 32'h0);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_ctrl", 32'(ctrl_sig), 32'h0);
        check("rst_addr", {17'h0, rs1_addr, rs2_addr, rd_addr}, 32'h0);

        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            check($sformatf("ctrl_%0d", k), 32'(ctrl_sig), 32'(exp_ctrl[k]));
            check($sformatf("wr_en_%0d", k), 32'(wr_en), 32'h1);
        end
        tick(1);
        check("R2_add", regs[2], 32'h0000001B);
        check("R3_sub", regs[3], 32'h00000003);
        check("R11_xor", regs[11], 32'h00000003);
        check("R14_or", regs[14], 32'h0000000F);
        check("R15_and", regs[15], 32'h0000000C);
        check("R6_sll", regs[6], 32'hF0000FF0);
        check("R12_srl", regs[12], 32'h0FF0000F);
        check("R13_sra", regs[13], 32'hFFF0000F);
        check("R9_slt", regs[9], 32'h0);
        check("R10_sltu", regs[10], 32'h1);
        check("nop_wr_en", 32'(wr_en), 32'h0);
        check("nop_rd_data", rd_data, 32'h0);
        check("pc_after_11", 32'(dut.PC), 32'd11);

        snap = wr_cnt;
`ifdef PC_HALT_EN
        tick(6);
        check("halt_pc", 32'(dut.PC), 32'd11);
        check("halt_instr", instr, 32'h00000013);
        check("halt_wr_en", 32'(wr_en), 32'h0);
        check("halt_writes", 32'(wr_cnt - snap), 32'h0);
`else
        budget = 0;
        while (dut.PC != 5'd31 && budget < 40) begin
            tick(1);
            budget++;
        end
        check("wrap_reach_top", 32'(dut.PC), 32'd31);
        check("wrap_cycles", 32'(budget), 32'd20);
        tick(1);
        check("wrap_to_zero", 32'(dut.PC), 32'h0);
        check("wrap_writes", 32'(wr_cnt - snap), 32'h0);
`endif

        set_init(32'd4, 32'hDEADBEEF);
        restart();
        tick(4);
        check("mid_inflight_wr", 32'(wr_en), 32'h1);
        check("mid_inflight_rd", 32'(rd_addr), 32'd9);
        snap = wr_cnt;
        rst = 1'b1;
        #1;
        check("mid_rst_pc", 32'(dut.PC), 32'h0);
        check("mid_rst_wr_en", 32'(wr_en), 32'h0);
        tick(1);
        check("mid_rst_R9", regs[9], 32'hDEADBEEF);
        check("mid_rst_writes", 32'(wr_cnt - snap), 32'h0);
        rst = 1'b0;
        tick(1);
        check("restart_ctrl", 32'(ctrl_sig), 32'h0);
        check("restart_rd", 32'(rd_addr), 32'd2);
        tick(10);
        check("restart_R9", regs[9], 32'h0);
        check("restart_R15", regs[15], 32'h0000000C);

        set_init(32'h00000024, 32'h0);
        restart();
        tick(11);
        check("mask_sll", regs[6], 32'hF0000FF0);
        check("mask_srl", regs[12], 32'h0FF0000F);
        check("mask_sra", regs[13], 32'hFFF0000F);
        check("mask_R2", regs[2], 32'h0000001B);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
